// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Pipelined barrel shifter with a valid/ready handshake. It supports logical
//   left (SLL), logical right (SRL), arithmetic right (SRA), rotate left (ROL)
//   and rotate right (ROR).
//
//   Stage k applies a shift or rotate of 2^k when bit k of the shift amount
//   is set; otherwise it passes the data through. The design therefore has
//   SH_W register stages, and the last stage drives the outputs.
//
//   One global advance signal moves the whole pipeline together. Bubbles are
//   not collapsed.
//
// Ports
//   clock      : sole clock, rising edge
//   reset_n    : synchronous active-low reset
//   in_valid   : operation presented
//   in_ready   : operation accepted this cycle (combinational from out_valid/out_ready)
//   in_data    : operand
//   in_shamt   : unsigned shift amount 0..WIDTH-1
//   in_op      : 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   in_tag     : opaque tag travelling with the operation
//   out_valid  : result available
//   out_ready  : consumer takes the result this cycle
//   out_data   : shifted result
//   out_tag    : tag of the result
//   out_zero   : out_valid && out_data == 0
//   out_err    : the operation carried an illegal opcode (data passed unshifted)
module pipelined_shifter #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 5,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_err
);

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // One shift level. An illegal opcode falls into the default branch,
    // which gives a shift by zero.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sgn,
        input int unsigned      amt
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   r;
        ext = {{WIDTH{sgn}}, d} >> amt;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = ext[WIDTH-1:0];
            // When amt is 0, the complementary shift by WIDTH yields 0,
            // so the rotate reduces cleanly to d.
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    // Stage registers
    logic             valid_r [SH_W];
    logic [WIDTH-1:0] data_r  [SH_W];
    logic [SH_W-1:0]  shamt_r [SH_W];
    logic [2:0]       op_r    [SH_W];
    logic [TAG_W-1:0] tag_r   [SH_W];
    logic             err_r   [SH_W];
    logic             sign_r  [SH_W];

    // Next values each stage loads when the pipeline advances
    logic             nxt_valid_s [SH_W];
    logic [WIDTH-1:0] nxt_data_s  [SH_W];
    logic [SH_W-1:0]  nxt_shamt_s [SH_W];
    logic [2:0]       nxt_op_s    [SH_W];
    logic [TAG_W-1:0] nxt_tag_s   [SH_W];
    logic             nxt_err_s   [SH_W];
    logic             nxt_sign_s  [SH_W];

    logic adv_s;

    // Global advance: the pipeline moves unless a result is waiting unconsumed.
    always_comb begin
        adv_s = !valid_r[SH_W-1] || out_ready;
    end

    // Per-stage next-state: select the predecessor, then apply this stage's 2^k level.
    always_comb begin
        for (int k = 0; k < SH_W; k++) begin
            logic [WIDTH-1:0] src_s;
            if (k == 0) begin
                nxt_valid_s[k] = in_valid;
                src_s          = in_data;
                nxt_shamt_s[k] = in_shamt;
                nxt_op_s[k]    = in_op;
                nxt_tag_s[k]   = in_tag;
                nxt_err_s[k]   = (in_op > 3'd4);
                nxt_sign_s[k]  = in_data[WIDTH-1];
            end else begin
                nxt_valid_s[k] = valid_r[k-1];
                src_s          = data_r[k-1];
                nxt_shamt_s[k] = shamt_r[k-1];
                nxt_op_s[k]    = op_r[k-1];
                nxt_tag_s[k]   = tag_r[k-1];
                nxt_err_s[k]   = err_r[k-1];
                nxt_sign_s[k]  = sign_r[k-1];
            end
            if (nxt_shamt_s[k][k]) begin
                nxt_data_s[k] = shift_step(src_s, nxt_op_s[k], nxt_sign_s[k], 32'd1 << k);
            end else begin
                nxt_data_s[k] = src_s;
            end
        end
    end

    // Pipeline registers: synchronous clear, otherwise load all stages together on advance.
    always_ff @(posedge clock) begin
        for (int k = 0; k < SH_W; k++) begin
            if (!reset_n) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= '0;
                shamt_r[k] <= '0;
                op_r[k]    <= 3'd0;
                tag_r[k]   <= '0;
                err_r[k]   <= 1'b0;
                sign_r[k]  <= 1'b0;
            end else if (adv_s) begin
                valid_r[k] <= nxt_valid_s[k];
                data_r[k]  <= nxt_data_s[k];
                shamt_r[k] <= nxt_shamt_s[k];
                op_r[k]    <= nxt_op_s[k];
                tag_r[k]   <= nxt_tag_s[k];
                err_r[k]   <= nxt_err_s[k];
                sign_r[k]  <= nxt_sign_s[k];
            end else begin
                valid_r[k] <= valid_r[k];
                data_r[k]  <= data_r[k];
                shamt_r[k] <= shamt_r[k];
                op_r[k]    <= op_r[k];
                tag_r[k]   <= tag_r[k];
                err_r[k]   <= err_r[k];
                sign_r[k]  <= sign_r[k];
            end
        end
    end

    // Outputs come straight from the last stage register.
    always_comb begin
        in_ready  = adv_s;
        out_valid = valid_r[SH_W-1];
        out_data  = data_r[SH_W-1];
        out_tag   = tag_r[SH_W-1];
        out_err   = err_r[SH_W-1];
        out_zero  = valid_r[SH_W-1] && (data_r[SH_W-1] == '0);
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

    logic        clock = 1'b0;
    logic        reset_n;

    // WIDTH = 32 instance
    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [2:0]  in_op;

    // WIDTH = 8 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_err;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt;
    logic [4:0]  b_in_tag, b_out_tag;
    logic [2:0]  b_in_op;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pipelined_shifter #(.WIDTH(32), .TAG_W(5)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err)
    );

    pipelined_shifter #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_zero(b_out_zero), .out_err(b_out_err)
    );

    // One isolated operation on the 32-bit instance: latency, data, tag, err, zero
    task automatic op32(input string name, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [4:0] tag,
                        input logic [31:0] exp_d, input logic exp_err);
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tag;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL %s early_valid got=%b want=0", name, out_valid);
        end
        @(posedge clock); #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL %s valid got=%b want=1", name, out_valid);
        end
        total++;
        if (out_data !== exp_d) begin
            bad++; $display("FAIL %s data got=%h want=%h", name, out_data, exp_d);
        end
        total++;
        if (out_tag !== tag || out_err !== exp_err || out_zero !== (exp_d == 32'd0)) begin
            bad++;
            $display("FAIL %s tag/err/zero got=%h/%b/%b want=%h/%b/%b", name, out_tag, out_err,
                     out_zero, tag, exp_err, (exp_d == 32'd0));
        end
    endtask

    // One isolated operation on the 8-bit instance (3-cycle latency)
    task automatic op8(input string name, input logic [2:0] op, input logic [7:0] d,
                       input logic [2:0] sh, input logic [7:0] exp_d, input logic exp_err);
        b_in_valid = 1'b1; b_in_op = op; b_in_data = d; b_in_shamt = sh; b_in_tag = 5'd9;
        @(posedge clock); #1;
        b_in_valid = 1'b0;
        @(posedge clock); #1;
        total++;
        if (b_out_valid !== 1'b0) begin
            bad++; $display("FAIL %s early_valid got=%b want=0", name, b_out_valid);
        end
        @(posedge clock); #1;
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== exp_d || b_out_err !== exp_err
            || b_out_tag !== 5'd9) begin
            bad++;
            $display("FAIL %s got v=%b d=%h e=%b t=%h want v=1 d=%h e=%b t=09", name,
                     b_out_valid, b_out_data, b_out_err, b_out_tag, exp_d, exp_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_tag !== 5'd0 || out_err !== 1'b0
            || out_zero !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset32 got v=%b d=%h t=%h e=%b z=%b r=%b want 0/0/0/0/0/1",
                     out_valid, out_data, out_tag, out_err, out_zero, in_ready);
        end
        total++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'd0 || b_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset8 got v=%b d=%h r=%b want 0/00/1", b_out_valid, b_out_data,
                     b_in_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_shifts32();
        op32("sll31",  3'b000, 32'h0000_0001, 5'd31, 5'd1, 32'h8000_0000, 1'b0);
        op32("sll0",   3'b000, 32'h0000_0001, 5'd0,  5'd2, 32'h0000_0001, 1'b0);
        op32("sra4",   3'b010, 32'h8000_0000, 5'd4,  5'd3, 32'hF800_0000, 1'b0);
        op32("srl4",   3'b001, 32'h8000_0000, 5'd4,  5'd4, 32'h0800_0000, 1'b0);
        op32("sra4p",  3'b010, 32'h7FFF_FFF0, 5'd4,  5'd5, 32'h07FF_FFFF, 1'b0);
        op32("rol1",   3'b011, 32'h8000_0001, 5'd1,  5'd6, 32'h0000_0003, 1'b0);
        op32("ror1",   3'b100, 32'h0000_0001, 5'd1,  5'd7, 32'h8000_0000, 1'b0);
        op32("rol16",  3'b011, 32'h1234_5678, 5'd16, 5'd8, 32'h5678_1234, 1'b0);
        op32("ror0",   3'b100, 32'hA5A5_0F0F, 5'd0,  5'd9, 32'hA5A5_0F0F, 1'b0);
    endtask

    task automatic test_zero_illegal();
        op32("srl_zero", 3'b001, 32'h0000_00F0, 5'd8, 5'd10, 32'h0000_0000, 1'b0);
        op32("illegal7", 3'b111, 32'hDEAD_BEEF, 5'd7, 5'd11, 32'hDEAD_BEEF, 1'b1);
        op32("illegal5", 3'b101, 32'h0000_0000, 5'd3, 5'd12, 32'h0000_0000, 1'b1);
    endtask

    task automatic test_width8();
        op8("w8_ror3", 3'b100, 8'h81, 3'd3, 8'h30, 1'b0);
        op8("w8_sll7", 3'b000, 8'h01, 3'd7, 8'h80, 1'b0);
        op8("w8_sra7", 3'b010, 8'h80, 3'd7, 8'hFF, 1'b0);
        op8("w8_rol5", 3'b011, 8'h81, 3'd5, 8'h30, 1'b0);
        op8("w8_ill",  3'b110, 8'h5A, 3'd2, 8'h5A, 1'b1);
    endtask

    // Eight SLL ops tags 0..7 (data t+1, shamt t) with a 3-cycle output stall
    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic stall_prev = 1'b0;
        logic accepted;
        logic [31:0] pd;
        logic [31:0] exp_d;
        logic [4:0] pt;
        logic pe;
        logic extra;
        pd = 32'd0; pt = 5'd0; pe = 1'b0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1; in_op = 3'b000; in_data = 32'(sent + 1);
                in_shamt = 5'(sent); in_tag = 5'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== pd || out_tag !== pt || out_err !== pe) begin
                    bad++;
                    $display("FAIL stall_hold got v=%b d=%h t=%h want v=1 d=%h t=%h",
                             out_valid, out_data, out_tag, pd, pt);
                end
            end
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready);
                end
            end
            stall_prev = out_valid && !out_ready;
            pd = out_data; pt = out_tag; pe = out_err;
            if (out_valid && out_ready) begin
                exp_d = 32'(got + 1) << got;
                total++;
                if (out_tag !== 5'(got) || out_data !== exp_d || out_err !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_out got t=%h d=%h want t=%h d=%h", out_tag, out_data,
                             5'(got), exp_d);
                end
                got++;
            end
            accepted = in_valid && in_ready;
            @(posedge clock); #1;
            if (accepted) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 8) begin
            bad++; $display("FAIL stream_count got=%0d want=8", got);
        end
        extra = 1'b0;
        repeat (7) begin
            if (out_valid !== 1'b0) extra = 1'b1;
            @(posedge clock); #1;
        end
        total++;
        if (extra !== 1'b0) begin
            bad++; $display("FAIL stream_dup got=%b want=0", extra);
        end
    endtask

    // Three ops in flight, then a one-cycle reset; nothing may emerge afterwards
    task automatic test_reset_mid();
        logic stale;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 3'b011; in_data = 32'hFFFF_0000;
            in_shamt = 5'(i); in_tag = 5'(20 + i);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_tag !== 5'd0 || out_err !== 1'b0
            || out_zero !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset got v=%b d=%h t=%h e=%b z=%b r=%b want 0/0/0/0/0/1",
                     out_valid, out_data, out_tag, out_err, out_zero, in_ready);
        end
        stale = 1'b0;
        repeat (8) begin
            @(posedge clock); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++; $display("FAIL midreset_stale got=%b want=0", stale);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; in_shamt = 5'd0; in_op = 3'd0; in_tag = 5'd0;
        out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 8'd0; b_in_shamt = 3'd0; b_in_op = 3'd0;
        b_in_tag = 5'd0; b_out_ready = 1'b1;
        test_reset();
        test_shifts32();
        test_zero_illegal();
        test_width8();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined barrel shifter with a valid/ready handshake, supporting logical left, logical right, arithmetic right, rotate-left and rotate-right. It generalises the ALU's 32-bit combinational left shifter: it takes arbitrary power-of-two widths, adds the right-shift and rotate modes, registers one shift level per pipeline stage, and can stall. It sits between the decode/issue logic and writeback, so long shift chains no longer limit the ALU critical path.

## Interface
Parameters:
- WIDTH, 32, data width; power of two, ≥ 4.
- TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. destination register).
- SH_W, $clog2(WIDTH), shift-amount width and pipeline depth. Derived; do not override.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SH_W  shift amount, unsigned, 0..WIDTH-1.
- in_op  input  3  operation select: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 illegal.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.
- out_zero  output  1  out_valid AND (out_data == 0).
- out_err  output  1  the operation carried an illegal in_op.

## Operation
- Pipeline depth: SH_W register stages. Stage k (k = 0..SH_W-1) applies a shift or rotate of 2^k when shamt bit k is 1, otherwise passes its data through unchanged. Stage SH_W-1 drives the outputs.
- Each stage register holds: valid, data, remaining shamt bits, op, tag, err, and sign.
- Sign is captured from in_data[WIDTH-1] at stage 0 and carried down the pipeline.
- Fill rules per stage:
  - SLL fills vacated LSBs with 0.
  - SRL fills vacated MSBs with 0.
  - SRA fills vacated MSBs with sign.
  - ROL/ROR reinsert the bits shifted out at the opposite end.
- Illegal op: treated as shift-by-0. out_data = in_data, out_err = 1. No other side effect.
- in_shamt = 0: out_data = in_data for every op, out_err = 0 when op is legal.
- Flow control uses one global advance signal: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 1, every stage loads from its predecessor. Stage 0 loads valid = in_valid.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed. A stalled empty stage still holds.
- Ordering: results leave in acceptance order. No operation is dropped or duplicated.
- out_data, out_tag and out_err must stay stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset: while reset_n = 0 at a rising edge, all stage valid bits, data, tag, err and sign are cleared to 0.
  - After reset: out_valid = 0, out_data = 0, out_tag = 0, out_err = 0, out_zero = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation: every in-flight operation is discarded. No stale result appears after reset_n returns to 1.
- Latency: an operation accepted at edge N (in_valid && in_ready) is presented with out_valid = 1 after edge N+SH_W-1, assuming no stall. That is SH_W cycles, e.g. 5 for WIDTH = 32.
- Throughput: one operation per cycle while out_ready = 1.
- Simultaneous events: output consumed and new input accepted in the same cycle is legal and required to work. This is the full-throughput steady state.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_* to out_*.
- Stall: while out_valid = 1 and out_ready = 0, in_ready = 0. Upstream must hold in_valid and its data.

## Test plan
- SLL, WIDTH = 32: in_data = 0x0000_0001, shamt = 31 -> out_data = 0x8000_0000 after 5 cycles. Same operand with shamt = 0 -> out_data = 0x0000_0001.
- Right shifts: 0x8000_0000, shamt = 4.
  - SRA -> 0xF800_0000.
  - SRL -> 0x0800_0000.
  - 0x7FFF_FFF0 SRA shamt 4 -> 0x07FF_FFFF.
- Rotates:
  - 0x8000_0001 ROL 1 -> 0x0000_0003.
  - 0x0000_0001 ROR 1 -> 0x8000_0000.
  - 0x1234_5678 ROL 16 -> 0x5678_1234.
- Zero and illegal op:
  - 0x0000_00F0 SRL 8 -> out_data = 0, out_zero = 1.
  - op = 3'b111, in_data = 0xDEAD_BEEF, shamt = 7 -> out_data = 0xDEAD_BEEF, out_err = 1.
- Backpressure: stream 8 ops with tags 0..7 and hold out_ready = 0 for 3 cycles mid-stream. Require:
  - in_ready = 0 during the stall.
  - outputs held stable.
  - all 8 tags emerge in order with correct data and no duplicates.
- Reset mid-stream: pull reset_n low for 1 cycle with 3 ops in flight.
  - All outputs must read 0 the next cycle.
  - No old tag appears afterwards.
  - Repeat the shift/rotate checks on a WIDTH = 8 instance (3-cycle latency): 0x81 ROR 3 -> 0x30.
